// File: rtl/tag_req_issuer.sv
// Tag request issuer: pairs upstream requests with id_tracker tags, issues them downstream,
// matches out-of-order responses and retires tags. Optional feature macro: TAG_REQ_ISSUER_TIMEOUT_EN.
module tag_req_issuer #(
    parameter int TAG_COUNT      = 4,
    parameter int TAG_WIDTH      = $clog2(TAG_COUNT),
    parameter int META_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    input  logic [META_WIDTH-1:0] req_meta,
    output logic                  req_ready,
    input  logic                  new_tag_ready,
    input  logic [TAG_WIDTH-1:0]  new_tag,
    output logic                  new_tag_consume,
    output logic                  issue_valid,
    output logic [TAG_WIDTH-1:0]  issue_tag,
    output logic [META_WIDTH-1:0] issue_meta,
    input  logic                  issue_ready,
    input  logic                  resp_valid,
    input  logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  done_valid,
    output logic [TAG_WIDTH-1:0]  done_tag,
    output logic [META_WIDTH-1:0] done_meta,
    output logic                  done_timeout,
    input  logic                  done_ready,
    output logic                  old_tag_done,
    output logic [TAG_WIDTH-1:0]  old_tag,
    output logic                  spurious_err,
    output logic [TAG_WIDTH:0]    outstanding_count
);

    typedef enum logic [2:0] {
        TAG_FREE,
        TAG_ISSUING,
        TAG_PENDING,
        TAG_RESPONDED,
        TAG_COMPLETING
    } tag_state_e;

    tag_state_e            state_q [TAG_COUNT];
    tag_state_e            state_d [TAG_COUNT];
    logic [META_WIDTH-1:0] meta_q  [TAG_COUNT];
    logic [META_WIDTH-1:0] meta_d  [TAG_COUNT];

    logic                  issue_valid_q, issue_valid_d;
    logic [TAG_WIDTH-1:0]  issue_tag_q, issue_tag_d;
    logic [META_WIDTH-1:0] issue_meta_q, issue_meta_d;
    logic                  done_valid_q, done_valid_d;
    logic [TAG_WIDTH-1:0]  done_tag_q, done_tag_d;
    logic [META_WIDTH-1:0] done_meta_q, done_meta_d;
    logic                  old_tag_done_q, old_tag_done_d;
    logic [TAG_WIDTH-1:0]  old_tag_q, old_tag_d;
    logic                  spurious_q, spurious_d;
    logic [TAG_WIDTH:0]    outstanding_q, outstanding_d;

    logic                  accept, issue_hs, done_hs, resp_hit, load_en, load_found;
    logic [TAG_WIDTH-1:0]  load_tag;

`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q [TAG_COUNT];
    logic [CNT_W-1:0] cnt_d [TAG_COUNT];
    logic             tmo_q [TAG_COUNT];
    logic             tmo_d [TAG_COUNT];
    logic             done_timeout_q, done_timeout_d;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < TAG_COUNT; i++) begin
                state_q[i] <= TAG_FREE;
                meta_q[i]  <= '0;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
                cnt_q[i]   <= '0;
                tmo_q[i]   <= 1'b0;
`endif
            end
            issue_valid_q  <= 1'b0;
            issue_tag_q    <= '0;
            issue_meta_q   <= '0;
            done_valid_q   <= 1'b0;
            done_tag_q     <= '0;
            done_meta_q    <= '0;
            old_tag_done_q <= 1'b0;
            old_tag_q      <= '0;
            spurious_q     <= 1'b0;
            outstanding_q  <= '0;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
            done_timeout_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < TAG_COUNT; i++) begin
                state_q[i] <= state_d[i];
                meta_q[i]  <= meta_d[i];
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
                cnt_q[i]   <= cnt_d[i];
                tmo_q[i]   <= tmo_d[i];
`endif
            end
            issue_valid_q  <= issue_valid_d;
            issue_tag_q    <= issue_tag_d;
            issue_meta_q   <= issue_meta_d;
            done_valid_q   <= done_valid_d;
            done_tag_q     <= done_tag_d;
            done_meta_q    <= done_meta_d;
            old_tag_done_q <= old_tag_done_d;
            old_tag_q      <= old_tag_d;
            spurious_q     <= spurious_d;
            outstanding_q  <= outstanding_d;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
            done_timeout_q <= done_timeout_d;
`endif
        end
    end

    // Handshake decode and lowest-index RESPONDED search for the done register.
    always_comb begin
        req_ready       = new_tag_ready & (~issue_valid_q | issue_ready);
        accept          = req_valid & req_ready;
        new_tag_consume = accept;
        issue_hs        = issue_valid_q & issue_ready;
        done_hs         = done_valid_q & done_ready;
        resp_hit        = resp_valid & (state_q[resp_tag] == TAG_PENDING);
        load_en         = ~done_valid_q | done_hs;
        load_found      = 1'b0;
        load_tag        = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (state_q[i] == TAG_RESPONDED) begin
                load_found = 1'b1;
                load_tag   = TAG_WIDTH'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < TAG_COUNT; i++) begin
            state_d[i] = state_q[i];
            meta_d[i]  = meta_q[i];
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
            cnt_d[i]   = cnt_q[i];
            tmo_d[i]   = tmo_q[i];
`endif
        end
        issue_valid_d  = issue_valid_q;
        issue_tag_d    = issue_tag_q;
        issue_meta_d   = issue_meta_q;
        done_valid_d   = done_valid_q;
        done_tag_d     = done_tag_q;
        done_meta_d    = done_meta_q;
        old_tag_done_d = done_hs;
        old_tag_d      = done_hs ? done_tag_q : old_tag_q;
        spurious_d     = spurious_q | (resp_valid & ~resp_hit);
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
        done_timeout_d = done_timeout_q;
`endif

        if (issue_hs) begin
            state_d[issue_tag_q] = TAG_PENDING;
            issue_valid_d        = 1'b0;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
            cnt_d[issue_tag_q]   = '0;
`endif
        end

`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
        // A real response in the expiry cycle wins over the timeout.
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (state_q[i] == TAG_PENDING && !(resp_hit && resp_tag == TAG_WIDTH'(i))) begin
                if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d[i] = TAG_RESPONDED;
                    tmo_d[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
`endif

        if (resp_hit) begin
            state_d[resp_tag] = TAG_RESPONDED;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
            tmo_d[resp_tag]   = 1'b0;
`endif
        end

        if (done_hs) begin
            state_d[done_tag_q] = TAG_FREE;
        end

        if (load_en) begin
            done_valid_d = load_found;
            if (load_found) begin
                state_d[load_tag] = TAG_COMPLETING;
                done_tag_d        = load_tag;
                done_meta_d       = meta_q[load_tag];
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
                done_timeout_d    = tmo_q[load_tag];
`endif
            end
        end

        if (accept) begin
            state_d[new_tag] = TAG_ISSUING;
            meta_d[new_tag]  = req_meta;
            issue_valid_d    = 1'b1;
            issue_tag_d      = new_tag;
            issue_meta_d     = req_meta;
        end

        outstanding_d = '0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (state_d[i] != TAG_FREE) begin
                outstanding_d = outstanding_d + (TAG_WIDTH + 1)'(1);
            end
        end
    end

    assign issue_valid       = issue_valid_q;
    assign issue_tag         = issue_tag_q;
    assign issue_meta        = issue_meta_q;
    assign done_valid        = done_valid_q;
    assign done_tag          = done_tag_q;
    assign done_meta         = done_meta_q;
    assign old_tag_done      = old_tag_done_q;
    assign old_tag           = old_tag_q;
    assign spurious_err      = spurious_q;
    assign outstanding_count = outstanding_q;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
    assign done_timeout      = done_timeout_q;
`else
    assign done_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_tag_req_issuer.sv
// Self-checking bench for tag_req_issuer: a set-based reference model plus an id_tracker model
// that hands out free tags and takes them back on old_tag_done.
module tb_tag_req_issuer;

    localparam int TC = 4;
    localparam int TW = 2;
    localparam int MW = 8;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          req_valid, req_ready, new_tag_ready, new_tag_consume;
    logic [MW-1:0] req_meta;
    logic [TW-1:0] new_tag;
    logic          issue_valid, issue_ready;
    logic [TW-1:0] issue_tag;
    logic [MW-1:0] issue_meta;
    logic          resp_valid;
    logic [TW-1:0] resp_tag;
    logic          done_valid, done_timeout, done_ready;
    logic [TW-1:0] done_tag;
    logic [MW-1:0] done_meta;
    logic          old_tag_done, spurious_err;
    logic [TW-1:0] old_tag;
    logic [TW:0]   outstanding_count;

    tag_req_issuer #(.TAG_COUNT(TC), .TAG_WIDTH(TW), .META_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_meta(req_meta), .req_ready(req_ready),
        .new_tag_ready(new_tag_ready), .new_tag(new_tag), .new_tag_consume(new_tag_consume),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_meta(issue_meta),
        .issue_ready(issue_ready),
        .resp_valid(resp_valid), .resp_tag(resp_tag),
        .done_valid(done_valid), .done_tag(done_tag), .done_meta(done_meta),
        .done_timeout(done_timeout), .done_ready(done_ready),
        .old_tag_done(old_tag_done), .old_tag(old_tag),
        .spurious_err(spurious_err), .outstanding_count(outstanding_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: which tags are in use, waiting for a response, or answered.
    bit            m_busy [TC];
    bit            m_pend [TC];
    bit            m_resp [TC];
    bit            m_rto  [TC];
    int            m_age  [TC];
    logic [MW-1:0] m_meta [TC];
    bit            trk_free [TC];
    bit            e_iv, e_dv, e_dto, e_od, e_sp;
    logic [TW-1:0] e_it, e_dt, e_ot;
    logic [MW-1:0] e_im, e_dm;
    int            dut_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TC; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_resp[i] = 0; m_rto[i] = 0;
            m_age[i] = 0; m_meta[i] = '0; trk_free[i] = 1;
        end
        e_iv = 0; e_dv = 0; e_dto = 0; e_od = 0; e_sp = 0;
        e_it = '0; e_dt = '0; e_ot = '0; e_im = '0; e_dm = '0;
    endtask

    // Compare every registered output against the model (called just after a falling edge).
    task automatic checkOutput();
        int busy_n = 0;
        for (int i = 0; i < TC; i++) busy_n += int'(m_busy[i]);
        check("issue_valid", issue_valid, e_iv);
        if (e_iv) begin
            check("issue_tag", issue_tag, e_it);
            check("issue_meta", issue_meta, e_im);
        end
        check("done_valid", done_valid, e_dv);
        if (e_dv) begin
            check("done_tag", done_tag, e_dt);
            check("done_meta", done_meta, e_dm);
            check("done_timeout", done_timeout, e_dto);
        end
        check("old_tag_done", old_tag_done, e_od);
        if (e_od) check("old_tag", old_tag, e_ot);
        check("spurious_err", spurious_err, e_sp);
        check("outstanding_count", outstanding_count, busy_n);
    endtask

    // Drive one cycle of inputs, check the combinational handshake, and advance the model.
    task automatic applyStimulus(input bit rv, input logic [MW-1:0] m, input int want,
                                 input bit ir, input bit rsv, input logic [TW-1:0] rt,
                                 input bit dr);
        int  ch = -1;
        int  ld = -1;
        bit  ntr, exp_rr, acc, ihs, dhs, resp_ok;
        bit  old_p [TC];
        bit  old_r [TC];
        if (want >= 0 && want < TC && trk_free[want]) ch = want;
        else for (int i = 0; i < TC; i++) if (ch < 0 && trk_free[i]) ch = i;
        ntr = (ch >= 0);
        new_tag_ready = ntr;
        new_tag       = ntr ? TW'(ch) : '0;
        req_valid     = rv;
        req_meta      = m;
        issue_ready   = ir;
        resp_valid    = rsv;
        resp_tag      = rt;
        done_ready    = dr;
        #1;
        exp_rr = ntr && (!e_iv || ir);
        check("req_ready", req_ready, exp_rr);
        check("new_tag_consume", new_tag_consume, rv && exp_rr);
        if (done_valid && done_ready) dut_log.push_back(int'(done_tag));

        acc = rv && exp_rr;
        ihs = e_iv && ir;
        dhs = e_dv && dr;
        old_p = m_pend;
        old_r = m_resp;
        resp_ok = rsv && m_pend[rt];
        if (rsv && !resp_ok) e_sp = 1;
        if (e_od) trk_free[e_ot] = 1;
        if (acc) trk_free[ch] = 0;
        if (!e_dv || dhs) begin
            for (int i = 0; i < TC; i++) if (ld < 0 && old_r[i]) ld = i;
        end
        if (dhs) m_busy[e_dt] = 0;
        e_od = dhs;
        if (dhs) e_ot = e_dt;
`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
        for (int i = 0; i < TC; i++) begin
            if (old_p[i] && !(resp_ok && int'(rt) == i)) begin
                if (m_age[i] == TO) begin
                    m_pend[i] = 0; m_resp[i] = 1; m_rto[i] = 1;
                end else begin
                    m_age[i]++;
                end
            end
        end
`endif
        if (resp_ok) begin
            m_pend[rt] = 0; m_resp[rt] = 1; m_rto[rt] = 0;
        end
        if (ihs) begin
            m_pend[e_it] = 1; m_age[e_it] = 0; e_iv = 0;
        end
        if (!e_dv || dhs) begin
            e_dv = (ld >= 0);
            if (ld >= 0) begin
                e_dt = TW'(ld); e_dm = m_meta[ld]; e_dto = m_rto[ld]; m_resp[ld] = 0;
            end
        end
        if (acc) begin
            m_busy[ch] = 1; m_meta[ch] = m;
            e_iv = 1; e_it = TW'(ch); e_im = m;
        end
    endtask

    task automatic cycle(input bit rv, input logic [MW-1:0] m, input int want, input bit ir,
                         input bit rsv, input logic [TW-1:0] rt, input bit dr);
        applyStimulus(rv, m, want, ir, rsv, rt, dr);
        @(negedge CLK);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) cycle(0, '0, -1, 1, 0, '0, dr);
    endtask

    // Asynchronous reset in mid-cycle: every output must drop at once, no retire pulse.
    task automatic doReset();
        @(negedge CLK);
        #2;
        nRST = 0;
        req_valid = 0; req_meta = '0; new_tag_ready = 0; new_tag = '0; issue_ready = 0;
        resp_valid = 0; resp_tag = '0; done_ready = 0;
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_timeout", done_timeout, 0);
        check("rst_old_tag_done", old_tag_done, 0);
        check("rst_spurious", spurious_err, 0);
        check("rst_outstanding", outstanding_count, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_consume", new_tag_consume, 0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1;
        model_reset();
        #1;
        checkOutput();
    endtask

    initial begin
        int ooo_exp [4] = '{3, 0, 1, 2};
        logic [TW-1:0] rt;
        nRST = 0;
        model_reset();
        doReset();

        // Single request: tag 2, meta A5, response three cycles after issue.
        cycle(1, 8'hA5, 2, 1, 0, '0, 1);
        check("single_issue_tag", issue_tag, 2);
        check("single_issue_meta", issue_meta, 8'hA5);
        check("single_outstanding1", outstanding_count, 1);
        idle(3, 0);
        cycle(0, '0, -1, 1, 1, 2'd2, 0);
        cycle(0, '0, -1, 1, 0, '0, 1);
        check("single_done_valid", done_valid, 1);
        check("single_done_tag", done_tag, 2);
        check("single_done_meta", done_meta, 8'hA5);
        cycle(0, '0, -1, 1, 0, '0, 1);
        check("single_old_tag_done", old_tag_done, 1);
        check("single_old_tag", old_tag, 2);
        check("single_outstanding0", outstanding_count, 0);
        idle(1, 1);
        check("single_pulse_end", old_tag_done, 0);
        idle(1, 1);

        // Out-of-order: tag 3 answers first and is loaded before the others respond.
        for (int t = 0; t < TC; t++) cycle(1, MW'(8'h10 + t), t, 1, 0, '0, 0);
        idle(1, 0);
        check("ooo_outstanding4", outstanding_count, 4);
        applyStimulus(1, 8'h55, -1, 1, 0, '0, 0);
        check("ooo_full_req_ready", req_ready, 0);
        @(negedge CLK); #1; checkOutput();
        cycle(0, '0, -1, 1, 1, 2'd3, 0);
        cycle(0, '0, -1, 1, 1, 2'd1, 0);
        cycle(0, '0, -1, 1, 1, 2'd0, 0);
        cycle(0, '0, -1, 1, 1, 2'd2, 0);
        idle(2, 0);
        dut_log.delete();
        idle(6, 1);
        check("ooo_count", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) check("ooo_order", dut_log[i], ooo_exp[i]);
        idle(2, 1);

        // Issue backpressure: the issue register holds and no new tag is taken.
        cycle(1, 8'h3C, 1, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'h77, 0, 0, 0, '0, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_consume", new_tag_consume, 0);
            @(negedge CLK); #1; checkOutput();
            check("bp_issue_tag", issue_tag, 1);
            check("bp_issue_meta", issue_meta, 8'h3C);
        end
        for (int i = 0; i < 3; i++) cycle(1, MW'($urandom), -1, 1, 0, '0, 1);

        // Randomized traffic; responses mostly target tags that are waiting.
        for (int n = 0; n < 400; n++) begin
            int start = $urandom % TC;
            rt = TW'(start);
            if ($urandom % 8 != 0) begin
                for (int k = 0; k < TC; k++) begin
                    if (m_pend[(start + k) % TC]) begin
                        rt = TW'((start + k) % TC);
                        break;
                    end
                end
            end
            cycle($urandom % 4 != 0, MW'($urandom), int'($urandom % TC), $urandom % 3 != 0,
                  $urandom % 3 == 0, rt, $urandom % 2 == 1);
        end

        // Reset with three tags waiting for responses.
        doReset();
        for (int t = 0; t < 3; t++) cycle(1, MW'(8'hC0 + t), t, 1, 0, '0, 0);
        idle(1, 0);
        check("mid_outstanding3", outstanding_count, 3);
        doReset();
        idle(2, 1);

`ifdef TAG_REQ_ISSUER_TIMEOUT_EN
        // Tag 0 never answered: it completes as a timeout and a late response is spurious.
        cycle(1, 8'h99, 0, 1, 0, '0, 0);
        idle(TO + 6, 0);
        check("tmo_done_valid", done_valid, 1);
        check("tmo_done_tag", done_tag, 0);
        check("tmo_done_timeout", done_timeout, 1);
        check("tmo_spurious_before", spurious_err, 0);
        idle(3, 1);
        cycle(0, '0, -1, 1, 1, 2'd0, 1);
        check("tmo_late_spurious", spurious_err, 1);
        doReset();
`endif

        // Spurious response to a free tag: sticky flag, nothing else moves.
        check("spur_before", spurious_err, 0);
        cycle(0, '0, -1, 1, 1, 2'd1, 1);
        check("spur_set", spurious_err, 1);
        check("spur_no_done", done_valid, 0);
        check("spur_outstanding", outstanding_count, 0);
        idle(3, 1);
        check("spur_sticky", spurious_err, 1);

        for (int n = 0; n < 100; n++) begin
            rt = TW'($urandom % TC);
            cycle($urandom % 2 == 0, MW'($urandom), int'($urandom % TC), $urandom % 2 == 0,
                  $urandom % 3 == 0, rt, $urandom % 3 != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
